// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port single-access memory arbiter (data port 0, fetch port 1)
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; default is fixed priority to port 0.
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          accept;
    logic          win;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;

`ifdef MEM_ARBITER_RR_EN
    logic          last;
`endif

    always_comb begin
        accept     = req0 | req1;
        win        = 1'b0;
        next_state = IDLE;
        if (req0 && req1) begin
`ifdef MEM_ARBITER_RR_EN
            // the port that was not granted most recently takes the tie
            win = ~last;
`else
            win = 1'b0;
`endif
        end else begin
            win = req1;
        end
        if (accept) begin
            next_state = win ? ACC1 : ACC0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
`ifdef MEM_ARBITER_RR_EN
            last      <= 1'b1;
`endif
        end else begin
            state <= next_state;
            gnt0  <= accept & ~win;
            gnt1  <= accept & win;
            done0 <= (state == ACC0);
            done1 <= (state == ACC1);
            if (state == ACC0 && !lat_we) begin
                rdata0 <= mem_rdata;
            end
            if (state == ACC1 && !lat_we) begin
                rdata1 <= mem_rdata;
            end
            if (accept) begin
                lat_we    <= win ? we1 : we0;
                lat_addr  <= win ? addr1 : addr0;
                lat_wdata <= win ? wdata1 : wdata0;
`ifdef MEM_ARBITER_RR_EN
                last      <= win;
`endif
            end
        end
    end

    // address/data registers only load on accept, so they hold through IDLE
    assign mem_addr  = lat_addr;
    assign mem_waddr = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_we    = (state != IDLE) & lat_we & ~rst;

endmodule
